// File: rtl/comparator_4b.sv
// Registered magnitude comparator: one-hot gt/eq/ls flags plus max/min,
// selectable signed or unsigned interpretation per sample.
module comparator_4b #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_ls_b,
    output logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] min_val
);

    logic             valid_d, valid_q;
    logic             gt_d, gt_q;
    logic             eq_d, eq_q;
    logic             ls_d, ls_q;
    logic [WIDTH-1:0] max_d, max_q;
    logic [WIDTH-1:0] min_d, min_q;

    logic eq_c;
    logic gt_c;

    always_comb begin
        eq_c = (a == b);
        // Flipping both MSBs maps two's-complement order onto unsigned order
        if (signed_mode) begin
            gt_c = ({~a[WIDTH-1], a[WIDTH-2:0]} > {~b[WIDTH-1], b[WIDTH-2:0]});
        end else begin
            gt_c = (a > b);
        end
    end

    always_comb begin
        valid_d = in_valid;
        gt_d    = gt_q;
        eq_d    = eq_q;
        ls_d    = ls_q;
        max_d   = max_q;
        min_d   = min_q;
        if (in_valid) begin
            gt_d  = gt_c;
            eq_d  = eq_c;
            ls_d  = ~gt_c & ~eq_c;
            max_d = (gt_c | eq_c) ? a : b;
            min_d = (gt_c | eq_c) ? b : a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            ls_q    <= 1'b0;
            max_q   <= '0;
            min_q   <= '0;
        end else begin
            valid_q <= valid_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            ls_q    <= ls_d;
            max_q   <= max_d;
            min_q   <= min_d;
        end
    end

    assign out_valid = valid_q;
    assign a_gt_b    = gt_q;
    assign a_eq_b    = eq_q;
    assign a_ls_b    = ls_q;
    assign max_val   = max_q;
    assign min_val   = min_q;

endmodule

// File: tb/tb_comparator_4b.sv
// Testbench for comparator_4b: directed, exhaustive and random samples
// checked against an integer-valued reference model.
module tb_comparator_4b;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         signed_mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         a_gt_b;
    logic         a_eq_b;
    logic         a_ls_b;
    logic [W-1:0] max_val;
    logic [W-1:0] min_val;

    int n_checks = 0;
    int n_fails  = 0;

    logic         e_valid, e_gt, e_eq, e_ls;
    logic [W-1:0] e_max, e_min;

    comparator_4b #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .signed_mode(signed_mode),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .a_gt_b     (a_gt_b),
        .a_eq_b     (a_eq_b),
        .a_ls_b     (a_ls_b),
        .max_val    (max_val),
        .min_val    (min_val)
    );

    always #5 clk = ~clk;

    function automatic int to_int(input logic [W-1:0] v, input logic sm);
        int r;
        r = int'(v);
        if (sm && r >= (1 << (W - 1))) r = r - (1 << W);
        return r;
    endfunction

    task automatic model_reset();
        e_valid = 0; e_gt = 0; e_eq = 0; e_ls = 0; e_max = '0; e_min = '0;
    endtask

    task automatic model_step(input logic v, input logic sm,
                              input logic [W-1:0] aa, input logic [W-1:0] bb);
        int ia, ib;
        e_valid = v;
        if (v) begin
            ia = to_int(aa, sm);
            ib = to_int(bb, sm);
            e_gt = (ia > ib);
            e_eq = (ia == ib);
            e_ls = (ia < ib);
            e_max = (ia >= ib) ? aa : bb;
            e_min = (ia >= ib) ? bb : aa;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
        check({tag, ".a_gt_b"}, 32'(a_gt_b), 32'(e_gt));
        check({tag, ".a_eq_b"}, 32'(a_eq_b), 32'(e_eq));
        check({tag, ".a_ls_b"}, 32'(a_ls_b), 32'(e_ls));
        check({tag, ".max_val"}, 32'(max_val), 32'(e_max));
        check({tag, ".min_val"}, 32'(min_val), 32'(e_min));
        if (out_valid)
            check({tag, ".onehot"}, 32'($countones({a_gt_b, a_eq_b, a_ls_b})), 32'd1);
    endtask

    task automatic drive(input string tag, input logic v, input logic sm,
                         input logic [W-1:0] aa, input logic [W-1:0] bb);
        @(negedge clk);
        in_valid = v; signed_mode = sm; a = aa; b = bb;
        @(posedge clk);
        model_step(v, sm, aa, bb);
        #1;
        check_all(tag);
    endtask

    logic [W-1:0] ua_tbl [9] = '{4'h0, 4'h1, 4'h2, 4'h5, 4'h7, 4'h8, 4'hC, 4'hF, 4'h0};
    logic [W-1:0] ub_tbl [9] = '{4'h0, 4'h0, 4'h3, 4'h5, 4'h6, 4'h8, 4'hD, 4'h1, 4'hF};
    logic [W-1:0] sa_tbl [3] = '{4'hF, 4'h8, 4'h0};
    logic [W-1:0] sb_tbl [3] = '{4'h1, 4'h7, 4'hF};

    initial begin
        rst_n = 0; in_valid = 0; signed_mode = 0; a = '0; b = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 9; i++) drive("unsigned", 1, 0, ua_tbl[i], ub_tbl[i]);
        for (int i = 0; i < 3; i++) drive("signed", 1, 1, sa_tbl[i], sb_tbl[i]);

        drive("gap_sample", 1, 0, 4'hF, 4'h1);
        for (int i = 0; i < 3; i++) drive("gap_idle", 0, 0, 4'h0, 4'h9);

        // reset asserted between edges must clear outputs at once
        drive("pre_async", 1, 1, 4'h3, 4'h3);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1;

        // in-flight sample discarded by mid-stream reset
        @(negedge clk);
        in_valid = 1; signed_mode = 0; a = 4'h7; b = 4'h6;
        #2;
        rst_n = 0;
        @(posedge clk);
        #1;
        check_all("midstream_reset");
        @(negedge clk);
        rst_n = 1; in_valid = 0;
        @(posedge clk);
        #1;
        check_all("post_release_idle");
        drive("resume", 1, 0, 4'h7, 4'h6);

        for (int m = 0; m < 2; m++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    drive("exhaustive", 1, m[0], x[W-1:0], y[W-1:0]);

        for (int i = 0; i < 300; i++)
            drive("random", $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  W'($urandom), W'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
